// File: rtl/jtopl_wrseq.sv
// Host-side write sequencer for the OPL CPU port. (reg, val) commands pass through a small FIFO.
// Each command plays out as an address strobe, a wait, a data strobe and a second wait.
// Optional feature macro JTOPL_WRSEQ_SKIP_EN drops commands that would rewrite an identical value.
module jtopl_wrseq #(
  parameter int DEPTH     = 4,
  parameter int ADDR_WAIT = 12,
  parameter int DATA_WAIT = 84,
  parameter int CNTW      = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_reg,
  input  logic [7:0] cmd_val,
  output logic       busy,
  output logic [7:0] opl_din,
  output logic       opl_addr,
  output logic       opl_cs_n,
  output logic       opl_wr_n
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_ADR, S_AWAIT, S_DAT, S_DWAIT} state_t;
  typedef struct packed {
    logic [7:0] rg;
    logic [7:0] val;
  } cmd_t;

  cmd_t            mem [DEPTH];
  logic [AW:0]     wr_ptr, rd_ptr;
  logic            empty, full, push, pop, skip;
  cmd_t            head;
  state_t          state;
  logic [CNTW-1:0] cnt;
  logic [7:0]      cur_val;

  // The extra wrap bit separates full from empty when the index bits match.
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign head      = mem[rd_ptr[AW-1:0]];
  assign pop       = cen && (state == S_IDLE) && !empty;
  assign busy      = !empty || (state != S_IDLE);

  // NOTE: the storage array has no reset; the pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {cmd_reg, cmd_val};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

`ifdef JTOPL_WRSEQ_SKIP_EN
  logic [7:0]   shadow_mem [256];
  logic [255:0] shadow_vld;
  logic [7:0]   cur_reg;
  logic         dat_entry;

  assign dat_entry = cen && (state == S_AWAIT) && (cnt == '0);
  assign skip      = shadow_vld[head.rg] && (shadow_mem[head.rg] == head.val) && (head.rg >= 8'h10);

  // Shadow data is only trusted where its valid bit is set, so clearing the bits empties it.
  always_ff @(posedge clk) begin
    if (dat_entry) shadow_mem[cur_reg] <= cur_val;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_vld <= '0;
      cur_reg    <= '0;
    end else begin
      if (dat_entry) shadow_vld[cur_reg] <= 1'b1;
      if (pop)       cur_reg <= head.rg;
    end
  end
`else
  assign skip = 1'b0;
`endif

  // Strobe outputs are set on the transition into ADR/DAT, so they are already registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      cur_val  <= '0;
      opl_cs_n <= 1'b1;
      opl_wr_n <= 1'b1;
      opl_addr <= 1'b0;
      opl_din  <= '0;
    end else if (cen) begin
      opl_cs_n <= 1'b1;
      opl_wr_n <= 1'b1;
      case (state)
        S_IDLE: begin
          if (!empty && !skip) begin
            cur_val  <= head.val;
            state    <= S_ADR;
            opl_cs_n <= 1'b0;
            opl_wr_n <= 1'b0;
            opl_addr <= 1'b0;
            opl_din  <= head.rg;
          end
        end
        S_ADR: begin
          cnt   <= CNTW'(ADDR_WAIT - 1);
          state <= S_AWAIT;
        end
        S_AWAIT: begin
          if (cnt == '0) begin
            state    <= S_DAT;
            opl_cs_n <= 1'b0;
            opl_wr_n <= 1'b0;
            opl_addr <= 1'b1;
            opl_din  <= cur_val;
          end else begin
            cnt <= cnt - CNTW'(1);
          end
        end
        S_DAT: begin
          cnt   <= CNTW'(DATA_WAIT - 1);
          state <= S_DWAIT;
        end
        S_DWAIT: begin
          if (cnt == '0) state <= S_IDLE;
          else           cnt   <= cnt - CNTW'(1);
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
